mem_port_arbiter: RTL and testbench

//  Shares one slow_memory port (128-bit line, 28-bit line address) between the I-cache and the D-cache.

---
 rtl/mem_if_pkg.sv | 19 +
 rtl/mem_port_arbiter_sat_counter.sv | 20 ++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared types for the slow-memory line interface and its port arbiter.
package mem_if_pkg;

    localparam int LINE_ADDR_W = 28;
    localparam int LINE_W      = 128;

    typedef enum logic [1:0] {
        IDLE,
        OWN_I,
        OWN_D,
        GAP
    } arb_state_t;

    typedef enum logic {
        OWN_SEL_I,
        OWN_SEL_D
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + ONE;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of the single slow-memory line port between I-cache and D-cache.
// One transaction at a time; a one-cycle gap follows every completion or abort.
module mem_port_arbiter
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = LINE_ADDR_W,
    parameter int DATA_W = LINE_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  grant_cnt_i,
    output logic [CNT_W-1:0]  grant_cnt_d
);

    arb_state_t state;
    owner_t     last_owner;
    logic       req_i, req_d;
    logic       inc_i, inc_d;

    assign req_i = i_read | i_write;
    assign req_d = d_read | d_write;

    // Completion wins over a same-cycle request drop; a drop without ready is an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= OWN_SEL_I;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i && req_d)
                        state <= (last_owner == OWN_SEL_I) ? OWN_D : OWN_I;
                    else if (req_i)
                        state <= OWN_I;
                    else if (req_d)
                        state <= OWN_D;
                end
                OWN_I: begin
                    if (mem_ready) begin
                        state      <= GAP;
                        last_owner <= OWN_SEL_I;
                    end else if (!req_i) begin
                        state <= GAP;
                    end
                end
                OWN_D: begin
                    if (mem_ready) begin
                        state      <= GAP;
                        last_owner <= OWN_SEL_D;
                    end else if (!req_d) begin
                        state <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign inc_i = (state == OWN_I) & mem_ready;
    assign inc_d = (state == OWN_D) & mem_ready;

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        case (state)
            OWN_I: begin
                mem_read  = i_read;
                mem_write = i_write;
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
                i_ready   = mem_ready;
            end
            OWN_D: begin
                mem_read  = d_read;
                mem_write = d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_ready   = mem_ready;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; each cache qualifies it with its own ready.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    sat_counter #(.CNT_W(CNT_W)) u_cnt_i (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_i),
        .count (grant_cnt_i)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_d (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_d),
        .count (grant_cnt_d)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: transaction-level model checked every cycle plus literal expectations per scenario.
module tb_mem_port_arbiter;

    localparam int AW  = 28;
    localparam int DW  = 128;
    localparam int CW  = 16;
    localparam int CWS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] i_wdata = '0, d_wdata = '0, mem_rdata = '0;

    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic          i_ready, d_ready, mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] grant_cnt_i, grant_cnt_d;

    logic [DW-1:0]  s_i_rdata, s_d_rdata, s_mem_wdata;
    logic           s_i_ready, s_d_ready, s_mem_read, s_mem_write;
    logic [AW-1:0]  s_mem_addr;
    logic [CWS-1:0] s_grant_cnt_i, s_grant_cnt_d;

    int tests = 0;
    int fails = 0;
    int glog[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_cnt_i(grant_cnt_i), .grant_cnt_d(grant_cnt_d)
    );

    // Narrow-counter copy on the same stimulus so saturation is reachable quickly.
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CWS)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(s_i_rdata), .i_ready(s_i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(s_d_rdata), .d_ready(s_d_ready),
        .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_cnt_i(s_grant_cnt_i), .grant_cnt_d(s_grant_cnt_d)
    );

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Model: who holds the port (0 none, 1 I, 2 D), whether the release cycle is pending,
    // who completed last, and unbounded completion counts.
    int m_own, m_last, m_cnt_i, m_cnt_d;
    bit m_gap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own = 0; m_gap = 0; m_last = 1; m_cnt_i = 0; m_cnt_d = 0;
        end else if (m_gap) begin
            m_gap = 0;
        end else if (m_own == 0) begin
            if ((i_read | i_write) && (d_read | d_write)) m_own = (m_last == 1) ? 2 : 1;
            else if (i_read | i_write)                    m_own = 1;
            else if (d_read | d_write)                    m_own = 2;
        end else if (mem_ready) begin
            if (m_own == 1) m_cnt_i++; else m_cnt_d++;
            m_last = m_own; m_own = 0; m_gap = 1;
        end else if (m_own == 1 ? !(i_read | i_write) : !(d_read | d_write)) begin
            m_own = 0; m_gap = 1;
        end
    end

    always @(negedge clk) begin
        logic          e_rd, e_wr, e_ir, e_dr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0; e_addr = '0; e_wd = '0;
        if (m_own == 1) begin
            e_rd = i_read; e_wr = i_write; e_addr = i_addr; e_wd = i_wdata; e_ir = mem_ready;
        end else if (m_own == 2) begin
            e_rd = d_read; e_wr = d_write; e_addr = d_addr; e_wd = d_wdata; e_dr = mem_ready;
        end
        chk("mem_read", mem_read, e_rd);
        chk("mem_write", mem_write, e_wr);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("i_ready", i_ready, e_ir);
        chk("d_ready", d_ready, e_dr);
        chk("i_rdata", i_rdata, mem_rdata);
        chk("d_rdata", d_rdata, mem_rdata);
        chk("grant_cnt_i", grant_cnt_i, sat(m_cnt_i, CW));
        chk("grant_cnt_d", grant_cnt_d, sat(m_cnt_d, CW));
        chk("s_mem_read", s_mem_read, e_rd);
        chk("s_i_ready", s_i_ready, e_ir);
        chk("s_d_ready", s_d_ready, e_dr);
        chk("s_grant_cnt_i", s_grant_cnt_i, sat(m_cnt_i, CWS));
        chk("s_grant_cnt_d", s_grant_cnt_d, sat(m_cnt_d, CWS));
        if (rst_n && i_ready) glog.push_back(1);
        if (rst_n && d_ready) glog.push_back(2);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Waits for the port to be requested, then returns ready lat cycles later (lat>=1).
    task automatic serve(input int lat);
        bit found;
        found = 0;
        for (int k = 0; k < 50; k++) begin
            #3;
            if (mem_read | mem_write) begin
                found = 1;
                break;
            end
            tick();
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL serve_timeout: got no request, expected one within 50 cycles");
            tick();
        end else begin
            for (int k = 1; k < lat; k++) begin
                @(posedge clk);
                #4;
            end
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
        end
    endtask

    initial begin
        int g0;
        logic [DW-1:0] rd;

        // Reset state
        #2;
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_cnt_i", grant_cnt_i, 16'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single D read: request in cycle 0, ready in cycle 5
        d_read = 1'b1; d_addr = 28'h0000010;
        #3 chk("t2_c0_mem_read", mem_read, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            #3;
            chk("t2_mem_addr", mem_addr, 28'h0000010);
            chk("t2_mem_read", mem_read, 1'b1);
            chk("t2_d_ready_early", d_ready, 1'b0);
        end
        tick();
        rd = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        mem_rdata = rd; mem_ready = 1'b1;
        #3;
        chk("t2_d_ready", d_ready, 1'b1);
        chk("t2_d_rdata", d_rdata, rd);
        chk("t2_i_ready", i_ready, 1'b0);
        tick();
        mem_ready = 1'b0; d_read = 1'b0;
        #3;
        chk("t2_c6_mem_read", mem_read, 1'b0);
        chk("t2_cnt_d", grant_cnt_d, 16'd1);
        tick();
        tick();

        // Asynchronous reset in the middle of a D transaction
        d_read = 1'b1; d_addr = 28'h0000040;
        tick();
        tick();
        #3 chk("t1_own_mem_read", mem_read, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t1_async_mem_read", mem_read, 1'b0);
        chk("t1_cnt_d", grant_cnt_d, 16'd0);
        chk("t1_cnt_i", grant_cnt_i, 16'd0);
        d_read = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Tie after reset: D first, I two idle cycles after d_ready
        i_read = 1'b1; i_addr = 28'hABCDE12;
        d_write = 1'b1; d_addr = 28'h0000020; d_wdata = 128'h5555_AAAA;
        #3 chk("t3_c0_mem_req", mem_read | mem_write, 1'b0);
        tick();
        #3;
        chk("t3_d_write", mem_write, 1'b1);
        chk("t3_d_addr", mem_addr, 28'h0000020);
        chk("t3_d_wdata", mem_wdata, 128'h5555_AAAA);
        chk("t3_i_ready_wait", i_ready, 1'b0);
        tick();
        mem_ready = 1'b1;
        #3;
        chk("t3_d_ready", d_ready, 1'b1);
        chk("t3_i_ready_during_d", i_ready, 1'b0);
        tick();
        mem_ready = 1'b0; d_write = 1'b0;
        #3 chk("t3_gap1", mem_read | mem_write, 1'b0);
        tick();
        #3 chk("t3_gap2", mem_read | mem_write, 1'b0);
        tick();
        #3;
        chk("t3_i_granted", mem_read, 1'b1);
        chk("t3_i_addr", mem_addr, 28'hABCDE12);
        mem_ready = 1'b1;
        #1 chk("t3_i_ready", i_ready, 1'b1);
        tick();
        mem_ready = 1'b0; i_read = 1'b0;
        tick();
        tick();

        // Abort by D, then a stray ready in IDLE
        d_read = 1'b1; d_addr = 28'h0000077;
        tick();
        tick();
        #3 chk("t5_own", mem_read, 1'b1);
        tick();
        d_read = 1'b0;
        #3;
        chk("t5_drop_mem_read", mem_read, 1'b0);
        chk("t5_drop_d_ready", d_ready, 1'b0);
        tick();
        #3 chk("t5_gap", mem_read, 1'b0);
        tick();
        mem_ready = 1'b1;
        #3;
        chk("t5_stray_i_ready", i_ready, 1'b0);
        chk("t5_stray_d_ready", d_ready, 1'b0);
        tick();
        mem_ready = 1'b0;
        #3;
        chk("t5_cnt_d", grant_cnt_d, 16'd1);
        chk("t5_cnt_i", grant_cnt_i, 16'd1);
        // Abort left last_owner at I, so a new tie still goes to D
        tick();
        i_read = 1'b1; d_read = 1'b1;
        tick();
        #3 chk("t5_tie_to_d", mem_addr, 28'h0000077);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; d_read = 1'b0;
        serve(1);
        i_read = 1'b0;
        tick();
        #3 chk("t5_cnt_i_after", grant_cnt_i, 16'd2);

        // Fairness under continuous requests from both sides
        do_reset();
        i_read = 1'b1; d_write = 1'b1;
        g0 = glog.size();
        for (int k = 0; k < 6; k++) serve(2);
        i_read = 1'b0; d_write = 1'b0;
        tick();
        tick();
        chk("t4_grants", glog.size() - g0, 6);
        for (int k = 0; k < 6 && (g0 + k) < glog.size(); k++)
            chk($sformatf("t4_order%0d", k), glog[g0 + k], (k % 2 == 0) ? 2 : 1);
        chk("t4_cnt_i", grant_cnt_i, 16'd3);
        chk("t4_cnt_d", grant_cnt_d, 16'd3);

        // Saturation on the narrow copy; the wide counter keeps counting
        do_reset();
        i_write = 1'b1;
        for (int k = 0; k < 15; k++) serve(1);
        #3 chk("t6_s_cnt_15", s_grant_cnt_i, 4'hF);
        tick();
        for (int k = 0; k < 3; k++) serve(1);
        i_write = 1'b0;
        tick();
        tick();
        #3;
        chk("t6_s_cnt_hold", s_grant_cnt_i, 4'hF);
        chk("t6_cnt_i", grant_cnt_i, 16'd18);
        chk("t6_s_cnt_d", s_grant_cnt_d, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
